data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Write-capable data-memory controller for the MEM stage of the pipelined CPU. It drives the external RAM1 SRAM chip (active-low EN/OE/WE, 18-bit address, 16-bit bidirectional data) through a registered multi-cycle state machine. Instruction fetch only ever reads RAM2; this block is the write side (plus data reads) of the same SRAM protocol. It accepts one load or store at a time over a req/ready handshake and reports completion with a one-cycle done pulse.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- req  in  1  access request; accepted on a rising edge where req=1 and ready=1
- wr  in  1  1 = store, 0 = load; sampled with req
- address  in  16  word address; latched on accept
- write_data  in  16  store data; latched on accept
- read_data  out  16  load result; registered, holds until the next load completes
- ready  out  1  1 only in IDLE; the block can accept a request
- done  out  1  one-cycle completion pulse
- RAM1EN  out  1  chip enable, active-low
- RAM1OE  out  1  output enable, active-low
- RAM1WE  out  1  write enable, active-low
- RAM1ADDR  out  18  {2'b00, latched address}
- RAM1DATA  inout  16  driven with latched write data only in WR_SETUP, WR_PULSE and WR_HOLD; otherwise high-Z

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_SAMPLE. All RAM1 control outputs are registered.
- IDLE: EN=1, OE=1, WE=1, bus Z. On accept, latch address and write_data, then go to WR_SETUP if wr=1, or RD_SETUP if wr=0.
- WR_SETUP: EN=0, WE=1, OE=1; address and data driven. Next state is WR_PULSE.
- WR_PULSE: WE=0, with EN, address and data unchanged. Next state is WR_HOLD.
- WR_HOLD: WE=1; address and data still driven, so hold time is one full cycle. Next state is IDLE.
- RD_SETUP: EN=0, OE=0, WE=1, bus Z. Next state is RD_SAMPLE.
- RD_SAMPLE: EN=0, OE=0. On the exiting edge, read_data <= RAM1DATA and the state goes to IDLE.
- WE and OE are never low together. The bus is never driven while OE=0.
- Inputs that change during an access are ignored; only latched values are used.
- req=0 in IDLE holds IDLE with all controls deasserted.

## Timing
- Reset (async, takes effect immediately):
  - state IDLE, EN/OE/WE = 1, RAM1ADDR = 0, bus Z
  - read_data = 0, done = 0, ready = 1
- Reset asserted mid-access aborts the access with no done pulse. A store aborted before WR_PULSE does not write.
- Let E0 be the accept edge.
- Store (default build):
  - WR_SETUP after E0, WR_PULSE after E1, WR_HOLD after E2.
  - done=1 during WR_HOLD.
  - IDLE and ready=1 after E3.
  - 4 cycles from accept to next accept.
- Load:
  - RD_SETUP after E0, RD_SAMPLE after E1.
  - read_data is valid and done=1 in the cycle after E2, in IDLE.
  - A new request may be accepted in that same cycle, giving 3 cycles per load back-to-back.
- done is never high for two consecutive cycles except when back-to-back accesses complete in successive cycles.

## Configuration
- Macro: DMEM_POSTED_WRITE_EN.
- Defined:
  - A store pulses done in the cycle after E0, during WR_SETUP, so the requester proceeds immediately.
  - The write still runs WR_SETUP, WR_PULSE, WR_HOLD, and ready stays 0 until IDLE.
  - No done pulse occurs in WR_HOLD.
  - Loads are unchanged.
- Undefined: store done occurs in WR_HOLD as described under Timing.

## Test plan
- Reset: assert RST mid-WR_PULSE -> EN/OE/WE all 1 immediately, bus Z, ready=1, done=0, read_data=0.
- Store: req=1, wr=1, address=16'h1234, write_data=16'hBEEF.
  - Bus model must see RAM1ADDR=18'h01234 and data 16'hBEEF stable across the whole WE=0 cycle.
  - WE is low for exactly 1 cycle, done for exactly 1 cycle in WR_HOLD.
  - ready returns after 4 cycles.
- Load: model returns 16'hBEEF at 16'h1234; req=1, wr=0 -> OE low for 2 cycles, bus never driven by the DUT, read_data=16'hBEEF with done=1 in the cycle after E2.
- Back-to-back: hold req=1 for load A=16'h0010, then store to 16'h0011 issued in A's done cycle.
  - Store is accepted that cycle.
  - Protocol checker: WE and OE never low together, and the bus is never driven while OE=0.
- Input stability: change address and write_data every cycle during a store -> SRAM receives the originally latched values.
- DMEM_POSTED_WRITE_EN: store accepted at E0 -> done=1 in the cycle after E0 and ready=0 until the cycle after E3; a load issued then returns the just-written value.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Requester-side handshake bundle for data_memory_ctrl: one load/store at a
// time over req/ready, with a one-cycle done pulse and a registered result.
interface data_memory_ctrl_if;
    logic        req;
    logic        wr;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        ready;
    logic        done;

    modport master (
        output req, wr, address, write_data,
        input  read_data, ready, done
    );

    modport slave (
        input  req, wr, address, write_data,
        output read_data, ready, done
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: MEM-stage controller for the RAM1 asynchronous SRAM.
// Stores run SETUP/PULSE/HOLD so address and data bracket the WE low cycle;
// loads run SETUP/SAMPLE and capture the bus on the exiting edge.
// Optional: DMEM_POSTED_WRITE_EN signals store completion at accept time
// while the SRAM write sequence still runs to completion.
module data_memory_ctrl (
    input  logic                CLK,
    input  logic                RST,
    data_memory_ctrl_if.slave   bus,
    output logic                RAM1EN,
    output logic                RAM1OE,
    output logic                RAM1WE,
    output logic [17:0]         RAM1ADDR,
    inout  wire  [15:0]         RAM1DATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_SETUP,
        S_RD_SAMPLE
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, oe_q, we_q, data_oe_q, ready_q, done_q;
    logic        en_d, oe_d, we_d, data_oe_d, ready_d, done_d;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic        accept;

    // Next state plus next values of every registered control, all decoded
    // from state_d so each pin changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    state_d = bus.wr ? S_WR_SETUP : S_RD_SETUP;
                end
            end
            S_WR_SETUP:  state_d = S_WR_PULSE;
            S_WR_PULSE:  state_d = S_WR_HOLD;
            S_WR_HOLD:   state_d = S_IDLE;
            S_RD_SETUP:  state_d = S_RD_SAMPLE;
            S_RD_SAMPLE: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        en_d      = (state_d == S_IDLE);
        oe_d      = !((state_d == S_RD_SETUP) || (state_d == S_RD_SAMPLE));
        we_d      = (state_d != S_WR_PULSE);
        data_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                    (state_d == S_WR_HOLD);
        ready_d   = (state_d == S_IDLE);
`ifdef DMEM_POSTED_WRITE_EN
        done_d    = (accept && bus.wr) || (state_q == S_RD_SAMPLE);
`else
        done_d    = (state_d == S_WR_HOLD) || (state_q == S_RD_SAMPLE);
`endif
    end

    // State, pin registers, latched request and load result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            if (accept) begin
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
            end
            if (state_q == S_RD_SAMPLE) begin
                rdata_q <= RAM1DATA;
            end
        end
    end

    assign RAM1EN        = en_q;
    assign RAM1OE        = oe_q;
    assign RAM1WE        = we_q;
    assign RAM1ADDR      = {2'b00, addr_q};
    assign RAM1DATA      = data_oe_q ? wdata_q : 'z;
    assign bus.read_data = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: SRAM bus model, protocol monitor, and an
// access-level reference model (latencies and memory contents per access).
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram1en, ram1oe, ram1we;
    logic [17:0] ram1addr;
    wire  [15:0] ram1_data;

    always #5 clk = ~clk;

    data_memory_ctrl_if bus_if ();

    data_memory_ctrl dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus_if.slave),
        .RAM1EN   (ram1en),
        .RAM1OE   (ram1oe),
        .RAM1WE   (ram1we),
        .RAM1ADDR (ram1addr),
        .RAM1DATA (ram1_data)
    );

    // SRAM chip model: drives the bus on a read, stores on WE low.
    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [33:0] wq[$];
    int unsigned proto_viol = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [15:0] last_rd;

    assign ram1_data = (!ram1en && !ram1oe) ? sram[ram1addr[15:0]] : 'z;

    always @(negedge clk) begin
        if (!rst) begin
            if ((!ram1we && !ram1oe) || (!ram1oe && dut.data_oe_q))
                proto_viol <= proto_viol + 1;
            if (!ram1en && !ram1we) begin
                sram[ram1addr[15:0]] <= ram1_data;
                wq.push_back({ram1addr, ram1_data});
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access from accept to ready; called at a negedge where ready is
    // expected high, returns at the negedge where ready is high again.
    task automatic run_access(input bit w, input logic [15:0] a, input logic [15:0] d,
                              input string tag);
        int unsigned done_k, n_done, ready_k, we_lo, oe_lo, exp_done_k;
        logic [15:0] rd_at_done;
        logic [33:0] captured;
        done_k = 0; n_done = 0; ready_k = 0; we_lo = 0; oe_lo = 0;
        rd_at_done = '0;
        check({tag, "_ready_in"}, bus_if.ready, 1'b1);
        wq.delete();
        bus_if.req        = 1'b1;
        bus_if.wr         = w;
        bus_if.address    = a;
        bus_if.write_data = d;
        @(posedge clk);
        for (int unsigned k = 1; k <= 8 && ready_k == 0; k++) begin
            @(negedge clk);
            if (bus_if.done) begin
                n_done++;
                if (done_k == 0) done_k = k;
                rd_at_done = bus_if.read_data;
            end
            if (!ram1we) we_lo++;
            if (!ram1oe) oe_lo++;
            if (w && k <= 3) begin
                check({tag, "_addr"}, ram1addr, {2'b00, a});
                check({tag, "_bus"}, ram1_data, d);
            end
            if (bus_if.ready) ready_k = k;
            bus_if.req        = 1'b0;
            bus_if.wr         = 1'($urandom);
            bus_if.address    = 16'($urandom);
            bus_if.write_data = 16'($urandom);
        end
`ifdef DMEM_POSTED_WRITE_EN
        exp_done_k = w ? 1 : 3;
`else
        exp_done_k = 3;
`endif
        check({tag, "_done_cycle"}, done_k, exp_done_k);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_ready_cycle"}, ready_k, w ? 4 : 3);
        check({tag, "_we_low"}, we_lo, w ? 1 : 0);
        check({tag, "_oe_low"}, oe_lo, w ? 0 : 2);
        check({tag, "_nwrites"}, wq.size(), w ? 1 : 0);
        if (w) begin
            captured = (wq.size() > 0) ? wq[0] : 34'h0;
            check({tag, "_sram_write"}, captured, {2'b00, a, d});
            ref_mem[a] = d;
            check({tag, "_rd_hold"}, bus_if.read_data, last_rd);
        end else begin
            check({tag, "_rdata"}, rd_at_done, ref_mem[a]);
            last_rd = ref_mem[a];
        end
    endtask

    initial begin
        logic [15:0] ra, rdat;
        int unsigned nd;
        rst = 1'b1;
        bus_if.req = 1'b0; bus_if.wr = 1'b0;
        bus_if.address = '0; bus_if.write_data = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {ram1en, ram1oe, ram1we}, 3'b111);
        check("rst_addr", ram1addr, 18'h0);
        check("rst_ready", bus_if.ready, 1'b1);
        check("rst_done", bus_if.done, 1'b0);
        check("rst_rdata", bus_if.read_data, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // Abort a store in the middle of its WE pulse.
        bus_if.req = 1'b1; bus_if.wr = 1'b1;
        bus_if.address = 16'h7777; bus_if.write_data = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        bus_if.req = 1'b0;
        @(negedge clk);
        check("abort_in_pulse", ram1we, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_ctrl", {ram1en, ram1oe, ram1we}, 3'b111);
        check("abort_bus_z", dut.data_oe_q, 1'b0);
        check("abort_ready", bus_if.ready, 1'b1);
        check("abort_done", bus_if.done, 1'b0);
        check("abort_rdata", bus_if.read_data, 16'h0);
        check("abort_addr", ram1addr, 18'h0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.done) nd++;
        end
        check("abort_no_done", nd, 0);

        // Directed store/load pair.
        run_access(1'b1, 16'h1234, 16'hBEEF, "st1234");
        @(negedge clk);
        run_access(1'b0, 16'h1234, 16'h0000, "ld1234");
        check("ld1234_beef", last_rd, 16'hBEEF);

        // Back-to-back: load A, then a store issued in A's done cycle.
        @(negedge clk);
        run_access(1'b1, 16'h0010, 16'hC0DE, "st0010");
        @(negedge clk);
        run_access(1'b0, 16'h0010, 16'h0000, "b2b_ld");
        run_access(1'b1, 16'h0011, 16'h1357, "b2b_st");
        run_access(1'b0, 16'h0011, 16'h0000, "b2b_ld11");

        // Fill a small address pool, then a random mix of accesses.
        for (int unsigned i = 0; i < 8; i++)
            run_access(1'b1, 16'h0100 + 16'(i), 16'($urandom), "fill");
        for (int unsigned i = 0; i < 40; i++) begin
            ra   = 16'h0100 + 16'($urandom_range(0, 7));
            rdat = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_access(1'($urandom), ra, rdat, "rnd");
        end

        @(negedge clk);
        check("protocol", proto_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
